// File: rtl/jtframe_pocket_vrx.sv
// jtframe_pocket_vrx: recovers pixel strobe, colour, blanking and frame size
// from the Pocket video stream sampled on falling edges of pck_rgb_clk.
module jtframe_pocket_vrx #(
    parameter int COLORW = 4,
    parameter int HW     = 12,
    parameter int VW     = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [23:0]           pck_rgb,
    input  logic                  pck_rgb_clk,
    input  logic                  pck_de,
    input  logic                  pck_hs,
    input  logic                  pck_vs,
    output logic                  pxl_cen,
    output logic [3*COLORW-1:0]   rgb,
    output logic                  LHBL,
    output logic                  LVBL,
    output logic                  hs,
    output logic                  vs,
    output logic [HW-1:0]         hact,
    output logic [VW-1:0]         vact,
    output logic                  size_valid,
    output logic                  frame_done,
    output logic                  mismatch
);
    logic          clk_d, armed, smp, close, mm_set;
    logic [HW-1:0] hcnt, last_w, cnt_in, width_nx;
    logic [VW-1:0] vline, vline_nx;

    // A vs closes any partial line exactly as an hs would, so both share this path.
    always_comb begin
        smp      = clk_d & ~pck_rgb_clk;
        cnt_in   = (pck_de && hcnt != '1) ? hcnt + HW'(1) : hcnt;
        close    = (pck_hs | pck_vs) && cnt_in != '0;
        vline_nx = (close && vline != '1) ? vline + VW'(1) : vline;
        width_nx = close ? cnt_in : last_w;
        mm_set   = close && armed && last_w != '0 && cnt_in != last_w;
    end

    // armed stays low until the first vs after reset, so a cut frame never reports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_d      <= 1'b0;
            armed      <= 1'b0;
            pxl_cen    <= 1'b0;
            rgb        <= '0;
            LHBL       <= 1'b0;
            LVBL       <= 1'b0;
            hs         <= 1'b0;
            vs         <= 1'b0;
            hact       <= '0;
            vact       <= '0;
            size_valid <= 1'b0;
            frame_done <= 1'b0;
            mismatch   <= 1'b0;
            hcnt       <= '0;
            last_w     <= '0;
            vline      <= '0;
        end else begin
            clk_d      <= pck_rgb_clk;
            pxl_cen    <= smp;
            frame_done <= smp & pck_vs & armed;
            if (smp) begin
                rgb      <= {pck_rgb[23 -: COLORW], pck_rgb[15 -: COLORW], pck_rgb[7 -: COLORW]};
                LHBL     <= pck_de;
                hs       <= pck_hs;
                vs       <= pck_vs;
                LVBL     <= pck_vs ? 1'b0 : pck_de ? 1'b1 : LVBL;
                hcnt     <= (pck_hs | pck_vs) ? '0 : cnt_in;
                mismatch <= mismatch | mm_set;
                if (pck_vs) begin
                    vline  <= '0;
                    last_w <= '0;
                    armed  <= 1'b1;
                    if (armed) begin
                        hact       <= width_nx;
                        vact       <= vline_nx;
                        size_valid <= 1'b1;
                    end
                end else begin
                    vline  <= vline_nx;
                    last_w <= width_nx;
                end
            end
        end
    end
endmodule

// File: tb/tb_jtframe_pocket_vrx.sv
// tb_jtframe_pocket_vrx: directed frames through the Pocket video receiver,
// pixel outputs checked against a scoreboard of expected samples.
module tb_jtframe_pocket_vrx;
    localparam int CW = 4;

    logic clk = 0, rst_n = 0, pck_rgb_clk = 0, pck_de = 0, pck_hs = 0, pck_vs = 0;
    logic [23:0] pck_rgb = 0;
    logic pxl_cen, LHBL, LVBL, hs, vs, size_valid, frame_done, mismatch;
    logic [3*CW-1:0] rgb;
    logic [11:0] hact;
    logic [10:0] vact;

    typedef struct packed {
        logic [3*CW-1:0] rgb;
        logic lhbl, lvbl, hs, vs, fd;
    } exp_t;

    exp_t q[$];
    int checks = 0, errors = 0;
    logic exp_lvbl = 0;

    jtframe_pocket_vrx #(.COLORW(CW), .HW(12), .VW(11)) dut (
        .clk(clk), .rst_n(rst_n), .pck_rgb(pck_rgb), .pck_rgb_clk(pck_rgb_clk),
        .pck_de(pck_de), .pck_hs(pck_hs), .pck_vs(pck_vs), .pxl_cen(pxl_cen),
        .rgb(rgb), .LHBL(LHBL), .LVBL(LVBL), .hs(hs), .vs(vs), .hact(hact),
        .vact(vact), .size_valid(size_valid), .frame_done(frame_done), .mismatch(mismatch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3*CW-1:0] rgb_of(input logic [23:0] d);
        return {d[23 -: CW], d[15 -: CW], d[7 -: CW]};
    endfunction

    task automatic px(input logic [23:0] d, input logic de, input logic h, input logic v, input logic fd);
        exp_t e;
        @(negedge clk);
        pck_rgb = d; pck_de = de; pck_hs = h; pck_vs = v; pck_rgb_clk = 1;
        exp_lvbl = v ? 1'b0 : de ? 1'b1 : exp_lvbl;
        e = '{rgb_of(d), de, exp_lvbl, h, v, fd};
        q.push_back(e);
        repeat (4) @(negedge clk);
        pck_rgb_clk = 0;
        @(negedge clk);
        chk("pxl_cen_latency", {31'd0, pxl_cen}, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic line(input int n);
        for (int i = 0; i < n; i++) px(24'($urandom), 1, 0, 0, 0);
        px(24'($urandom), 0, 1, 0, 0);
    endtask

    task automatic frame(input int w, input int h, input logic fd);
        for (int i = 0; i < h; i++) line(w);
        px(24'($urandom), 0, 0, 1, fd);
    endtask

    task automatic sizes(input string tag, input int ha, input int va, input logic sv, input logic mm);
        chk({tag, "_hact"}, 32'(hact), 32'(ha));
        chk({tag, "_vact"}, 32'(vact), 32'(va));
        chk({tag, "_size_valid"}, {31'd0, size_valid}, {31'd0, sv});
        chk({tag, "_mismatch"}, {31'd0, mismatch}, {31'd0, mm});
    endtask

    task automatic in_reset();
        @(negedge clk);
        rst_n = 0;
        exp_lvbl = 0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_outputs", {pxl_cen, rgb, LHBL, LVBL, hs, vs, size_valid, frame_done, mismatch}, 0);
            chk("rst_sizes", {hact, vact}, 0);
        end
        rst_n = 1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (pxl_cen) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_pxl_cen: observed 1 expected 0");
                end else begin
                    e = q.pop_front();
                    chk("rgb", 32'(rgb), 32'(e.rgb));
                    chk("LHBL", {31'd0, LHBL}, {31'd0, e.lhbl});
                    chk("LVBL", {31'd0, LVBL}, {31'd0, e.lvbl});
                    chk("hs", {31'd0, hs}, {31'd0, e.hs});
                    chk("vs", {31'd0, vs}, {31'd0, e.vs});
                    chk("frame_done", {31'd0, frame_done}, {31'd0, e.fd});
                end
            end else if (frame_done) begin
                chk("frame_done_idle", {31'd0, frame_done}, 0);
            end
        end
    end

    initial begin
        in_reset();
        px(0, 0, 0, 1, 0);
        sizes("arm", 0, 0, 0, 0);
        frame(32, 12, 1);
        sizes("frame1", 32, 12, 1, 0);
        frame(32, 12, 1);
        sizes("frame2", 32, 12, 1, 0);
        px(24'hF3A50C, 1, 0, 0, 0);
        chk("rgb_hold_F3A50C", 32'(rgb), 32'h0FA0);
        px(0, 0, 0, 1, 1);
        sizes("one_px", 1, 1, 1, 0);
        frame(24, 4, 1);
        sizes("w24", 24, 4, 1, 0);
        px(0, 0, 0, 1, 1);
        sizes("empty", 0, 0, 1, 0);
        for (int i = 0; i < 300; i++) px(24'($urandom), 1, 0, 0, 0);
        px(0, 0, 0, 1, 1);
        sizes("no_hs", 300, 1, 1, 0);
        for (int i = 0; i < 3; i++) line(16);
        for (int i = 0; i < 16; i++) px(24'($urandom), 1, 0, 0, 0);
        px(0, 0, 1, 1, 1);
        sizes("hs_vs", 16, 4, 1, 0);
        line(32); line(31); line(32);
        px(0, 0, 0, 1, 1);
        sizes("short_line", 32, 3, 1, 1);
        frame(32, 12, 1);
        sizes("sticky", 32, 12, 1, 1);
        for (int i = 0; i < 10; i++) px(24'($urandom), 1, 0, 0, 0);
        in_reset();
        for (int i = 0; i < 5; i++) px(24'($urandom), 1, 0, 0, 0);
        px(0, 0, 0, 1, 0);
        sizes("cut_frame", 0, 0, 0, 0);
        frame(32, 12, 1);
        sizes("after_reset", 32, 12, 1, 0);
        repeat (4) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
